// File: rtl/job_controller_if.sv
// Host/pool-facing signal bundle of the job controller.
// The controller takes the slave modport; the driver of job commands, hits and reads takes master.
interface job_controller_if #(
    parameter int POOL_SIZE         = 4,
    parameter int POOL_SIZE_LOG2    = 2,
    parameter int NONCE_WIDTH       = 32,
    parameter int RESULT_DEPTH_LOG2 = 2
);
    logic                                  job_start_in;
    logic                                  abort_in;
    logic [POOL_SIZE-1:0]                  hit_in;
    logic [NONCE_WIDTH-POOL_SIZE_LOG2-1:0] hit_nonce_in;
    logic                                  exhausted_in;
    logic                                  core_reset_out;
    logic                                  core_hold_out;
    logic                                  result_rd_in;
    logic [NONCE_WIDTH-1:0]                result_out;
    logic                                  result_valid_out;
    logic [RESULT_DEPTH_LOG2:0]            result_count_out;
    logic                                  overflow_out;
    logic                                  busy_out;
    logic                                  ready_out;

    modport slave (
        input  job_start_in, abort_in, hit_in, hit_nonce_in, exhausted_in, result_rd_in,
        output core_reset_out, core_hold_out, result_out, result_valid_out,
               result_count_out, overflow_out, busy_out, ready_out
    );

    modport master (
        output job_start_in, abort_in, hit_in, hit_nonce_in, exhausted_in, result_rd_in,
        input  core_reset_out, core_hold_out, result_out, result_valid_out,
               result_count_out, overflow_out, busy_out, ready_out
    );
endinterface

// File: rtl/job_controller.sv
// Job sequencer for the hasher pool: starts and aborts jobs, and serialises per-unit hits
// into {unit_idx, nonce} results queued in a small show-ahead FIFO for the host.
module job_controller #(
    parameter int POOL_SIZE         = 4,
    parameter int POOL_SIZE_LOG2    = 2,
    parameter int NONCE_WIDTH       = 32,
    parameter int RESULT_DEPTH      = 4,
    parameter int RESULT_DEPTH_LOG2 = 2,
    parameter int STOP_WHEN_FULL    = 1
) (
    input logic              clk_in,
    input logic              reset_in,
    job_controller_if.slave  bus
);
    localparam int HN_W  = NONCE_WIDTH - POOL_SIZE_LOG2;
    localparam int CNT_W = RESULT_DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, DONE} state_t;

    state_t                     state, next_state;
    logic [POOL_SIZE-1:0]       pending, pending_next, src, hit_rest, pend_rest;
    logic [HN_W-1:0]            pend_nonce, pend_nonce_next;
    logic                       exh_latch, exh_next;
    logic                       core_reset, core_hold, overflow, valid;
    logic [NONCE_WIDTH-1:0]     mem [RESULT_DEPTH];
    logic [RESULT_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]           count, count_next;
    logic                       push_req, push_ok, pop, flush, overflow_set;
    logic [NONCE_WIDTH-1:0]     push_data;

    function automatic logic [POOL_SIZE_LOG2-1:0] lowest_idx(input logic [POOL_SIZE-1:0] v);
        logic [POOL_SIZE_LOG2-1:0] idx;
        idx = '0;
        for (int i = POOL_SIZE - 1; i >= 0; i--) begin
            if (v[i]) idx = POOL_SIZE_LOG2'(i);
        end
        return idx;
    endfunction

    assign hit_rest  = bus.hit_in & (bus.hit_in - POOL_SIZE'(1));
    assign pend_rest = pending & (pending - POOL_SIZE'(1));

    // Next-state, hit serialisation and FIFO bookkeeping; abort beats start, start beats everything else.
    always_comb begin
        next_state      = state;
        pending_next    = pending;
        pend_nonce_next = pend_nonce;
        exh_next        = exh_latch;
        src             = '0;
        push_req        = 1'b0;
        flush           = 1'b0;
        overflow_set    = 1'b0;

        if (bus.abort_in) begin
            next_state   = IDLE;
            pending_next = '0;
            exh_next     = 1'b0;
        end else if (bus.job_start_in) begin
            next_state   = START;
            flush        = 1'b1;
            pending_next = '0;
            exh_next     = 1'b0;
        end else begin
            case (state)
                START: next_state = RUN;
                RUN: begin
                    if (bus.hit_in != '0) begin
                        src      = bus.hit_in;
                        push_req = 1'b1;
                        if (hit_rest != '0) begin
                            pending_next    = hit_rest;
                            pend_nonce_next = bus.hit_nonce_in;
                            exh_next        = bus.exhausted_in;
                            next_state      = DRAIN;
                        end else if (bus.exhausted_in) begin
                            next_state = DONE;
                        end
                    end else if (bus.exhausted_in) begin
                        next_state = DONE;
                    end
                end
                DRAIN: begin
                    src          = pending;
                    push_req     = 1'b1;
                    pending_next = pend_rest;
                    if (pend_rest == '0) next_state = exh_latch ? DONE : RUN;
                end
                default: ;
            endcase
        end

        push_data = {lowest_idx(src), (state == DRAIN) ? pend_nonce : bus.hit_nonce_in};
        pop       = bus.result_rd_in && (count != '0) && !flush;
        push_ok   = push_req && ((count < CNT_W'(RESULT_DEPTH)) || pop);
        if (push_req && !push_ok) overflow_set = 1'b1;

        if (flush) count_next = '0;
        else       count_next = count + CNT_W'(push_ok) - CNT_W'(pop);

        // Filling the FIFO ends the job when configured to; leftover drain bits are lost.
        if (STOP_WHEN_FULL != 0 && push_ok && count_next == CNT_W'(RESULT_DEPTH)) begin
            next_state = DONE;
            if (pending_next != '0) overflow_set = 1'b1;
            pending_next = '0;
            exh_next     = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state      <= IDLE;
            pending    <= '0;
            pend_nonce <= '0;
            exh_latch  <= 1'b0;
            core_reset <= 1'b1;
            core_hold  <= 1'b0;
            overflow   <= 1'b0;
            valid      <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            for (int i = 0; i < RESULT_DEPTH; i++) mem[i] <= '0;
        end else begin
            state      <= next_state;
            pending    <= pending_next;
            pend_nonce <= pend_nonce_next;
            exh_latch  <= exh_next;
            core_reset <= (next_state == IDLE) || (next_state == START) || (next_state == DONE);
            core_hold  <= (next_state == DRAIN);
            count      <= count_next;
            valid      <= (count_next != '0);
            if (flush)             overflow <= 1'b0;
            else if (overflow_set) overflow <= 1'b1;
            if (flush)        wr_ptr <= '0;
            else if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (flush)        rd_ptr <= '0;
            else if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok) mem[wr_ptr] <= push_data;
        end
    end

    assign bus.core_reset_out   = core_reset;
    assign bus.core_hold_out    = core_hold;
    assign bus.result_out       = mem[rd_ptr];
    assign bus.result_valid_out = valid;
    assign bus.result_count_out = count;
    assign bus.overflow_out     = overflow;
    assign bus.busy_out         = (state == RUN) || (state == DRAIN);
    assign bus.ready_out        = valid || (state == DONE);
endmodule

// File: tb/tb_job_controller.sv
// Directed bench for job_controller: one instance stops when its FIFO fills, the other keeps
// searching and flags overflow; both receive identical stimulus.
module tb_job_controller;
    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        job_start = 1'b0, abort = 1'b0, exhausted = 1'b0, result_rd = 1'b0;
    logic [3:0]  hit = '0;
    logic [29:0] hit_nonce = '0;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk_in = ~clk_in;

    job_controller_if bus_stop ();
    job_controller_if bus_cont ();

    assign bus_stop.job_start_in = job_start;
    assign bus_stop.abort_in     = abort;
    assign bus_stop.hit_in       = hit;
    assign bus_stop.hit_nonce_in = hit_nonce;
    assign bus_stop.exhausted_in = exhausted;
    assign bus_stop.result_rd_in = result_rd;
    assign bus_cont.job_start_in = job_start;
    assign bus_cont.abort_in     = abort;
    assign bus_cont.hit_in       = hit;
    assign bus_cont.hit_nonce_in = hit_nonce;
    assign bus_cont.exhausted_in = exhausted;
    assign bus_cont.result_rd_in = result_rd;

    job_controller #(.STOP_WHEN_FULL(1)) dut_stop (.clk_in(clk_in), .reset_in(reset_in), .bus(bus_stop));
    job_controller #(.STOP_WHEN_FULL(0)) dut_cont (.clk_in(clk_in), .reset_in(reset_in), .bus(bus_cont));

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        repeat (2) cycle();
        compared++; if (bus_stop.core_reset_out !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_core_reset: got %0h want 1", bus_stop.core_reset_out); end
        compared++; if (bus_stop.core_hold_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_core_hold: got %0h want 0", bus_stop.core_hold_out); end
        compared++; if (bus_stop.result_valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %0h want 0", bus_stop.result_valid_out); end
        compared++; if (bus_stop.result_count_out !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d want 0", bus_stop.result_count_out); end
        compared++; if (bus_stop.result_out !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_result: got %h want 0", bus_stop.result_out); end
        compared++; if (bus_stop.overflow_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overflow: got %0h want 0", bus_stop.overflow_out); end
        compared++; if (bus_stop.busy_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %0h want 0", bus_stop.busy_out); end
        compared++; if (bus_stop.ready_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready: got %0h want 0", bus_stop.ready_out); end
        reset_in = 1'b0;
        cycle();
    endtask

    task automatic test_start();
        job_start = 1'b1;
        cycle();
        job_start = 1'b0;
        compared++; if (bus_stop.core_reset_out !== 1'b1) begin mismatched++; $display("[TB] FAIL start_core_reset: got %0h want 1", bus_stop.core_reset_out); end
        compared++; if (bus_stop.ready_out !== 1'b0) begin mismatched++; $display("[TB] FAIL start_ready: got %0h want 0", bus_stop.ready_out); end
        cycle();
        compared++; if (bus_stop.core_reset_out !== 1'b0) begin mismatched++; $display("[TB] FAIL run_core_reset: got %0h want 0", bus_stop.core_reset_out); end
        compared++; if (bus_stop.busy_out !== 1'b1) begin mismatched++; $display("[TB] FAIL run_busy: got %0h want 1", bus_stop.busy_out); end
    endtask

    task automatic test_single_hit();
        hit = 4'b0100; hit_nonce = 30'h0000_1234;
        cycle();
        hit = '0;
        compared++; if (bus_stop.result_out !== 32'h8000_1234) begin mismatched++; $display("[TB] FAIL single_result: got %h want 80001234", bus_stop.result_out); end
        compared++; if (bus_stop.result_count_out !== 3'd1) begin mismatched++; $display("[TB] FAIL single_count: got %0d want 1", bus_stop.result_count_out); end
        compared++; if (bus_stop.ready_out !== 1'b1) begin mismatched++; $display("[TB] FAIL single_ready: got %0h want 1", bus_stop.ready_out); end
        result_rd = 1'b1;
        cycle();
        result_rd = 1'b0;
        compared++; if (bus_stop.result_count_out !== 3'd0) begin mismatched++; $display("[TB] FAIL single_pop_count: got %0d want 0", bus_stop.result_count_out); end
        compared++; if (bus_stop.ready_out !== 1'b0) begin mismatched++; $display("[TB] FAIL single_pop_ready: got %0h want 0", bus_stop.ready_out); end
    endtask

    task automatic test_multi_hit();
        hit = 4'b1011; hit_nonce = 30'h5;
        cycle();
        hit = '0;
        compared++; if (bus_stop.core_hold_out !== 1'b1) begin mismatched++; $display("[TB] FAIL multi_hold1: got %0h want 1", bus_stop.core_hold_out); end
        compared++; if (bus_stop.result_count_out !== 3'd1) begin mismatched++; $display("[TB] FAIL multi_count1: got %0d want 1", bus_stop.result_count_out); end
        cycle();
        compared++; if (bus_stop.core_hold_out !== 1'b1) begin mismatched++; $display("[TB] FAIL multi_hold2: got %0h want 1", bus_stop.core_hold_out); end
        cycle();
        compared++; if (bus_stop.core_hold_out !== 1'b0) begin mismatched++; $display("[TB] FAIL multi_hold3: got %0h want 0", bus_stop.core_hold_out); end
        compared++; if (bus_stop.result_count_out !== 3'd3) begin mismatched++; $display("[TB] FAIL multi_count3: got %0d want 3", bus_stop.result_count_out); end
        compared++; if (bus_stop.busy_out !== 1'b1) begin mismatched++; $display("[TB] FAIL multi_busy: got %0h want 1", bus_stop.busy_out); end
        compared++; if (bus_stop.result_out !== 32'h0000_0005) begin mismatched++; $display("[TB] FAIL multi_head0: got %h want 00000005", bus_stop.result_out); end
        result_rd = 1'b1;
        cycle();
        compared++; if (bus_stop.result_out !== 32'h4000_0005) begin mismatched++; $display("[TB] FAIL multi_head1: got %h want 40000005", bus_stop.result_out); end
        cycle();
        compared++; if (bus_stop.result_out !== 32'hC000_0005) begin mismatched++; $display("[TB] FAIL multi_head2: got %h want C0000005", bus_stop.result_out); end
        cycle();
        result_rd = 1'b0;
        compared++; if (bus_stop.result_count_out !== 3'd0) begin mismatched++; $display("[TB] FAIL multi_drained: got %0d want 0", bus_stop.result_count_out); end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 5; k++) begin
            hit = 4'b0001; hit_nonce = 30'(k);
            cycle();
        end
        hit = '0;
        compared++; if (bus_cont.result_count_out !== 3'd4) begin mismatched++; $display("[TB] FAIL ovf_cont_count: got %0d want 4", bus_cont.result_count_out); end
        compared++; if (bus_cont.overflow_out !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_cont_flag: got %0h want 1", bus_cont.overflow_out); end
        compared++; if (bus_cont.busy_out !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_cont_busy: got %0h want 1", bus_cont.busy_out); end
        compared++; if (bus_stop.busy_out !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_stop_busy: got %0h want 0", bus_stop.busy_out); end
        compared++; if (bus_stop.overflow_out !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_stop_flag: got %0h want 0", bus_stop.overflow_out); end
        compared++; if (bus_stop.ready_out !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_stop_ready: got %0h want 1", bus_stop.ready_out); end
        job_start = 1'b1;
        cycle();
        job_start = 1'b0;
        compared++; if (bus_cont.result_count_out !== 3'd0) begin mismatched++; $display("[TB] FAIL restart_count: got %0d want 0", bus_cont.result_count_out); end
        compared++; if (bus_cont.overflow_out !== 1'b0) begin mismatched++; $display("[TB] FAIL restart_overflow: got %0h want 0", bus_cont.overflow_out); end
        cycle();
    endtask

    task automatic test_stop_full();
        for (int k = 1; k <= 3; k++) begin
            hit = 4'b0001; hit_nonce = 30'(k);
            cycle();
        end
        hit = 4'b0011; hit_nonce = 30'h7;
        cycle();
        hit = '0;
        compared++; if (bus_stop.result_count_out !== 3'd4) begin mismatched++; $display("[TB] FAIL full_count: got %0d want 4", bus_stop.result_count_out); end
        compared++; if (bus_stop.overflow_out !== 1'b1) begin mismatched++; $display("[TB] FAIL full_overflow: got %0h want 1", bus_stop.overflow_out); end
        compared++; if (bus_stop.core_reset_out !== 1'b1) begin mismatched++; $display("[TB] FAIL full_core_reset: got %0h want 1", bus_stop.core_reset_out); end
        compared++; if (bus_stop.busy_out !== 1'b0) begin mismatched++; $display("[TB] FAIL full_busy: got %0h want 0", bus_stop.busy_out); end
        compared++; if (bus_stop.result_out !== 32'h0000_0001) begin mismatched++; $display("[TB] FAIL full_head: got %h want 00000001", bus_stop.result_out); end
        compared++; if (bus_cont.core_hold_out !== 1'b1) begin mismatched++; $display("[TB] FAIL full_cont_hold: got %0h want 1", bus_cont.core_hold_out); end
        cycle();
        compared++; if (bus_cont.overflow_out !== 1'b1) begin mismatched++; $display("[TB] FAIL full_cont_overflow: got %0h want 1", bus_cont.overflow_out); end
        compared++; if (bus_cont.core_hold_out !== 1'b0) begin mismatched++; $display("[TB] FAIL full_cont_release: got %0h want 0", bus_cont.core_hold_out); end
        compared++; if (bus_cont.result_count_out !== 3'd4) begin mismatched++; $display("[TB] FAIL full_cont_count: got %0d want 4", bus_cont.result_count_out); end
    endtask

    task automatic test_exhaust();
        job_start = 1'b1;
        cycle();
        job_start = 1'b0;
        cycle();
        hit = 4'b0110; hit_nonce = 30'h3; exhausted = 1'b1;
        cycle();
        hit = '0; exhausted = 1'b0;
        compared++; if (bus_stop.busy_out !== 1'b1) begin mismatched++; $display("[TB] FAIL exh_multi_busy: got %0h want 1", bus_stop.busy_out); end
        cycle();
        compared++; if (bus_stop.busy_out !== 1'b0) begin mismatched++; $display("[TB] FAIL exh_multi_done: got %0h want 0", bus_stop.busy_out); end
        compared++; if (bus_stop.result_count_out !== 3'd2) begin mismatched++; $display("[TB] FAIL exh_multi_count: got %0d want 2", bus_stop.result_count_out); end
        compared++; if (bus_stop.result_out !== 32'h4000_0003) begin mismatched++; $display("[TB] FAIL exh_multi_head: got %h want 40000003", bus_stop.result_out); end
        job_start = 1'b1;
        cycle();
        job_start = 1'b0;
        cycle();
        hit = 4'b0010; hit_nonce = 30'h9; exhausted = 1'b1;
        cycle();
        hit = '0; exhausted = 1'b0;
        compared++; if (bus_stop.result_out !== 32'h4000_0009) begin mismatched++; $display("[TB] FAIL exh_single_head: got %h want 40000009", bus_stop.result_out); end
        compared++; if (bus_stop.busy_out !== 1'b0) begin mismatched++; $display("[TB] FAIL exh_single_busy: got %0h want 0", bus_stop.busy_out); end
        compared++; if (bus_stop.core_reset_out !== 1'b1) begin mismatched++; $display("[TB] FAIL exh_single_core_reset: got %0h want 1", bus_stop.core_reset_out); end
        abort = 1'b1; job_start = 1'b1;
        cycle();
        abort = 1'b0; job_start = 1'b0;
        compared++; if (bus_stop.result_count_out !== 3'd1) begin mismatched++; $display("[TB] FAIL abort_keeps_fifo: got %0d want 1", bus_stop.result_count_out); end
        cycle();
        compared++; if (bus_stop.busy_out !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_idle_busy: got %0h want 0", bus_stop.busy_out); end
        compared++; if (bus_stop.core_reset_out !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_idle_core_reset: got %0h want 1", bus_stop.core_reset_out); end
    endtask

    task automatic test_pop_empty();
        result_rd = 1'b1;
        cycle();
        compared++; if (bus_stop.result_count_out !== 3'd0) begin mismatched++; $display("[TB] FAIL pop_last: got %0d want 0", bus_stop.result_count_out); end
        cycle();
        result_rd = 1'b0;
        compared++; if (bus_stop.result_count_out !== 3'd0) begin mismatched++; $display("[TB] FAIL pop_empty: got %0d want 0", bus_stop.result_count_out); end
        compared++; if (bus_stop.ready_out !== 1'b0) begin mismatched++; $display("[TB] FAIL pop_empty_ready: got %0h want 0", bus_stop.ready_out); end
    endtask

    task automatic test_reset_midjob();
        job_start = 1'b1;
        cycle();
        job_start = 1'b0;
        cycle();
        hit = 4'b0001; hit_nonce = 30'h1;
        cycle();
        hit = '0;
        reset_in = 1'b1;
        #2;
        compared++; if (bus_stop.result_count_out !== 3'd0) begin mismatched++; $display("[TB] FAIL midjob_reset_count: got %0d want 0", bus_stop.result_count_out); end
        compared++; if (bus_stop.busy_out !== 1'b0) begin mismatched++; $display("[TB] FAIL midjob_reset_busy: got %0h want 0", bus_stop.busy_out); end
        compared++; if (bus_stop.core_reset_out !== 1'b1) begin mismatched++; $display("[TB] FAIL midjob_reset_core: got %0h want 1", bus_stop.core_reset_out); end
        cycle();
        reset_in = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_start();
        test_single_hit();
        test_multi_hit();
        test_overflow();
        test_stop_full();
        test_exhaust();
        test_pop_empty();
        test_reset_midjob();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/job_controller.md
Name: job_controller

Overview:
- Sequencing and result-collection block between the external IO interface and the hasher pool.
- Starts and aborts jobs, and holds the pool in reset while idle or finished.
- Serialises per-unit success flags into full 32-bit nonces, with the unit index folded in; previously the index bits were zero-filled.
- Buffers up to RESULT_DEPTH results so the search continues after the first hit, and raises a ready indication for the host.

Parameters:
- POOL_SIZE, 4, number of hasher units in the pool.
- POOL_SIZE_LOG2, 2, log2(POOL_SIZE); width of the unit index.
- NONCE_WIDTH, 32, width of a full result nonce.
- RESULT_DEPTH, 4, result FIFO entries (power of 2).
- RESULT_DEPTH_LOG2, 2, log2(RESULT_DEPTH).
- STOP_WHEN_FULL, 1, 1 = finish the job when the FIFO fills; 0 = keep searching, drop extra results and flag overflow.

Ports:
- clk_in  input  1  global clock.
- reset_in  input  1  asynchronous, active-high reset.
- job_start_in  input  1  single-cycle pulse: job config is latched, begin search.
- abort_in  input  1  single-cycle pulse: stop the job and return to IDLE.
- hit_in  input  POOL_SIZE  per-unit success flags, valid for one cycle.
- hit_nonce_in  input  NONCE_WIDTH-POOL_SIZE_LOG2  pool counter value belonging to hit_in.
- exhausted_in  input  1  pool has issued its last nonce; single-cycle pulse.
- core_reset_out  output  1  high = hold pool in reset.
- core_hold_out  output  1  high = pool must not advance its counter.
- result_rd_in  input  1  pop the head of the FIFO; ignored when empty.
- result_out  output  NONCE_WIDTH  FIFO head, show-ahead: {unit_idx, hit_nonce}.
- result_valid_out  output  1  FIFO non-empty.
- result_count_out  output  RESULT_DEPTH_LOG2+1  FIFO occupancy.
- overflow_out  output  1  sticky: a result was dropped.
- busy_out  output  1  state is RUN or DRAIN.
- ready_out  output  1  result_valid_out OR state is DONE; drives the tri-state ready_n line.

Behaviour:
- Reset values (asynchronous, on reset_in high):
  - state = IDLE
  - core_reset_out = 1, core_hold_out = 0
  - FIFO empty: result_valid_out = 0, result_count_out = 0, result_out = 0
  - overflow_out = 0, busy_out = 0, ready_out = 0
  - pending vector = 0, exhausted latch = 0
- States: IDLE, START, RUN, DRAIN, DONE. All outputs are registered except ready_out and busy_out, which decode from registers.
- IDLE: core_reset_out = 1. On job_start_in: flush the FIFO, clear overflow, go to START.
- START: lasts exactly one cycle; core_reset_out = 1. Then go to RUN; core_reset_out = 0 from the first RUN cycle.
- RUN, hit handling, when hit_in != 0:
  - Push {index of lowest set bit, hit_nonce_in}.
  - Exactly one bit set: stay in RUN.
  - More than one bit set: latch the remaining bits and hit_nonce_in, assert core_hold_out next cycle, go to DRAIN.
- DRAIN: push the lowest remaining bit each cycle, using the latched nonce. When the last bit is pushed, deassert core_hold_out and go to RUN, or to DONE if the exhausted latch is set. N simultaneous hits take N-1 DRAIN cycles.
- RUN, exhaustion:
  - exhausted_in without a hit: go to DONE.
  - exhausted_in together with a multi-hit: latch exhausted and finish DRAIN first.
  - exhausted_in together with a single hit: push, then go to DONE.
- DONE: core_reset_out = 1; FIFO contents are retained. job_start_in goes to START and flushes the FIFO.
- abort_in, in any non-IDLE state: go to IDLE next cycle. Pending bits and the exhausted latch clear; the FIFO is kept. abort_in wins over a simultaneous job_start_in.
- FIFO push acceptance: a push is accepted if count < RESULT_DEPTH, or if result_rd_in is valid in the same cycle.
  - Simultaneous push and pop on a non-empty FIFO: count unchanged.
  - Pop on an empty FIFO: no effect.
- FIFO full:
  - STOP_WHEN_FULL = 1: when a push makes count = RESULT_DEPTH, go to DONE, abandoning any pending DRAIN bits and setting overflow_out if any bits were left.
  - STOP_WHEN_FULL = 0: a rejected push sets overflow_out and the search continues.
- overflow_out clears only on reset or job_start_in.
- Pointers wrap modulo RESULT_DEPTH; count saturates at RESULT_DEPTH.
- hit_in is ignored outside RUN; in DRAIN the pool is held, so no new hits arrive.
- reset_in mid-job returns to IDLE immediately; FIFO contents are lost.

Test Plan:
- Reset, then job_start_in -> core_reset_out 1 for START, 0 from the next cycle; busy_out = 1; ready_out = 0.
- RUN, hit_in = 4'b0100, hit_nonce_in = 30'h0000_1234 -> result_out = 32'h8000_1234, count = 1, ready_out = 1. One result_rd_in -> count = 0, ready_out = 0.
- hit_in = 4'b1011, nonce = 30'h5 -> pushes 32'h0000_0005, 32'h4000_0005, 32'hC000_0005 over 3 consecutive cycles; core_hold_out high for exactly 2 cycles; return to RUN.
- STOP_WHEN_FULL = 0, depth 4: five single hits with no reads -> count = 4, overflow_out = 1, state stays RUN. job_start_in -> count = 0, overflow_out = 0.
- STOP_WHEN_FULL = 1, three entries queued, then hit_in = 4'b0011 -> 4th entry pushed, state DONE, overflow_out = 1, core_reset_out = 1.
- Single hit and exhausted_in in the same cycle -> result pushed, state DONE. Then abort_in and job_start_in together -> IDLE.
